ahb_mem_responder: RTL
======================

# ahb_mem_responder

AHB-Lite slave memory that answers the cache's downstream master port: single transfers and 4-beat WRAP4/INCR4 bursts, with a programmable number of wait states per beat. It sits on the downstream side of the I-cache as its backing instruction/data store in simulation and FPGA builds. It also flags burst-address sequencing violations, so the cache's refill logic can be checked cycle by cycle.

## Interface
- MEM_BYTES, 65536: memory size in bytes; power of two, ≥16.
- WAIT_STATES, 1: hready-low cycles inserted before each data beat completes (0..15).
- INIT_FILE, "": hex file loaded with $readmemh at elaboration; empty means zero-filled.

- hclk  in  1  AHB clock; all state on rising edge.
- hrstn  in  1  reset; asynchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  32  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size; only 3'b010 (word) is legal.
- hburst  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3; other encodings are treated as INCR.
- hwdata  in  32  write data, valid in the data phase.
- hrdata  out  32  read data, valid when hready=1 in a read data phase.
- hready  out  1  transfer done / bus ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- seq_viol  out  1  one-cycle pulse when a SEQ address differs from the expected burst address.

## Operation
- Address phase is accepted when hsel & hready & htrans∈{NONSEQ,SEQ}. On acceptance, register haddr, hwrite, hburst and an error flag.
- Error condition: haddr ≥ MEM_BYTES, haddr[1:0]≠0, or hsize≠word.
- IDLE/BUSY transfers, or hsel=0, while hready=1: no data phase; the next cycle gives an OKAY response with zero waits.
- FSM states:
  - S_IDLE: hready=1, hresp=0.
  - S_WAIT: counter loaded with WAIT_STATES−1 and decremented each cycle; hready=0. Exit to S_DATA when the counter reaches 0.
  - S_DATA: hready=1, hresp=0; read data is driven and write data is committed.
  - S_ERR1: hresp=1, hready=0.
  - S_ERR2: hresp=1, hready=1.
- Transitions on acceptance (from S_IDLE, S_DATA or S_ERR2):
  - error → S_ERR1;
  - WAIT_STATES=0 → S_DATA;
  - otherwise → S_WAIT.
  - With no acceptance, S_DATA and S_ERR2 return to S_IDLE. S_ERR1 always goes to S_ERR2.
- Reads: hrdata = mem[addr_q[log2(MEM_BYTES)-1:2]] in S_DATA. In all other states hrdata holds its last value.
- Writes: mem[index] ← hwdata at the clock edge ending S_DATA. A read of the same word in the immediately following beat returns the new data.
- Burst tracking: on an accepted NONSEQ, compute the expected next address.
  - WRAP4: {a[31:4], a[3:2]+1, 2'b00}.
  - INCR4/INCR: a+4.
  - SINGLE: no expectation.
  - Each accepted SEQ updates the expectation from its own address.
  - If a SEQ address ≠ expected, or a SEQ arrives with no burst open, pulse seq_viol in the next cycle. The beat is still serviced normally.
  - An INCR4/WRAP4 burst closes after its 4th beat.
- BUSY inside a burst: no effect on the expectation or on the beat count.
- Reset (any time, including mid-burst or in S_WAIT): FSM → S_IDLE, hready=1, hresp=0, hrdata=0, seq_viol=0, burst tracker cleared. Memory contents are not cleared.

## Timing
- Read latency: data is valid WAIT_STATES+1 cycles after the address-phase edge.
- Back-to-back with WAIT_STATES=0: one beat per cycle. A WRAP4 of 4 beats takes 5 cycles from NONSEQ to last data.
- Per-beat cost is WAIT_STATES+1 cycles, so a WRAP4 takes 4·(WAIT_STATES+1) cycles of data phase.
- ERROR response is always exactly 2 cycles. An address phase presented during S_ERR1 is not accepted because hready=0.
- seq_viol is registered and asserted exactly one cycle after the offending address phase.

## Structure
- interface_pkg gets these additions: the TRANS_TYPES enum (IDLE, BUSY, NONSEQ, SEQ), a BURST_TYPES enum (SINGLE, INCR, WRAP4, INCR4), HRESP_OKAY/HRESP_ERROR, and HSIZE_WORD.
- Sub-module ahb_burst_addr_gen: combinational next-address and beat-count logic for a given hburst. It is reused later by the cache master for self-checking.

## Test plan
- Preload mem[0x10..0x1C]=0xA0..0xA3. WRAP4 read starting at 0x18, WAIT_STATES=0 → beats return 0xA2, 0xA3, 0xA0, 0xA1 on 4 consecutive cycles; seq_viol stays 0.
- WAIT_STATES=2, single read of 0x0 → hready low for 2 cycles, then high with hrdata=mem[0].
- Write 0xDEADBEEF to 0x40, then immediately read 0x40 → 0xDEADBEEF returned in the next beat.
- Read 0x10000 with MEM_BYTES=65536 → hresp=1 & hready=0, then hresp=1 & hready=1, then back to OKAY. Repeat with haddr=0x2 and hsize=0.
- WRAP4 at 0x18, second beat driven as SEQ to 0x20 → seq_viol pulses one cycle later; data for 0x20 is still returned.
- Assert hrstn low in S_WAIT during beat 2 of a burst → outputs reset asynchronously (hready=1, hresp=0, hrdata=0); a subsequent NONSEQ is serviced normally and memory contents are intact.

Source files
------------

// File: rtl/ahb_mem_responder_pkg.sv
// Shared AHB-Lite encodings and responder FSM states for the memory responder
// and its burst address generator.
package ahb_mem_responder_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } trans_types_t;

    // Encoding is local to this bus: WRAP4=2, INCR4=3; other values act as INCR.
    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3
    } burst_types_t;

    localparam logic       HRESP_OKAY   = 1'b0;
    localparam logic       HRESP_ERROR  = 1'b1;
    localparam logic [2:0] HSIZE_WORD   = 3'b010;
    localparam int         BURST4_BEATS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

endpackage

// File: rtl/ahb_mem_responder_burst_addr_gen.sv
// Combinational next-address and beat-count logic for one burst beat; shared
// with the cache master's refill checker.
module ahb_burst_addr_gen
    import ahb_mem_responder_pkg::*;
(
    input  logic [2:0]  burst,
    input  logic [31:0] addr,
    input  logic [2:0]  beat_cnt,
    output logic [31:0] next_addr,
    output logic [2:0]  next_beat_cnt,
    output logic        last_beat
);

    // beat_cnt counts beats before this one; last_beat means nothing may follow.
    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        next_beat_cnt = beat_cnt + 3'd1;
        next_addr     = addr + 32'd4;
        last_beat     = 1'b0;
        case (burst)
            BURST_SINGLE: last_beat = 1'b1;
            BURST_WRAP4: begin
                next_addr = {addr[31:4], addr[3:2] + 2'd1, 2'b00};
                last_beat = (next_beat_cnt == 3'(BURST4_BEATS));
            end
            BURST_INCR4: last_beat = (next_beat_cnt == 3'(BURST4_BEATS));
            default:     last_beat = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite word memory with programmable wait states, two-cycle ERROR response
// and a burst sequencing checker that pulses seq_viol on bad SEQ addresses.
module ahb_mem_responder
    import ahb_mem_responder_pkg::*;
#(
    parameter int    MEM_BYTES   = 65536,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic        seq_viol
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int DEPTH = MEM_BYTES / 4;

    logic [31:0] mem [DEPTH];

    state_t        state, next_state;
    logic [3:0]    wait_cnt;
    logic [31:0]   addr_q;
    logic          write_q;
    logic [2:0]    burst_q;
    logic [31:0]   hrdata_q;
    logic [AW-3:0] mem_idx;

    logic          is_nonseq, is_seq, accept, addr_err;

    logic          burst_open;
    logic [31:0]   exp_addr;
    logic [2:0]    beat_q;
    logic [2:0]    gen_burst, gen_beat, gen_next_beat;
    logic [31:0]   gen_next_addr;
    logic          gen_last;

    assign is_nonseq = (htrans == TRANS_NONSEQ);
    assign is_seq    = (htrans == TRANS_SEQ);
    assign accept    = hsel && hready && (is_nonseq || is_seq);
    assign addr_err  = (haddr >= 32'(MEM_BYTES)) || (haddr[1:0] != 2'b00)
                       || (hsize != HSIZE_WORD);
    assign mem_idx   = addr_q[AW-1:2];

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (state)
            S_WAIT: hready = 1'b0;
            S_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            S_ERR2:  hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_WAIT: if (wait_cnt == 4'd0) next_state = S_DATA;
            S_ERR1: next_state = S_ERR2;
            default: begin
                if (!accept)                next_state = S_IDLE;
                else if (addr_err)          next_state = S_ERR1;
                else if (WAIT_STATES == 0)  next_state = S_DATA;
                else                        next_state = S_WAIT;
            end
        endcase
    end

    // Between read data phases the bus keeps showing the last word returned.
    assign hrdata = (state == S_DATA && !write_q) ? mem[mem_idx] : hrdata_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state    <= next_state;
            hrdata_q <= hrdata;
            if (accept) begin
                addr_q   <= haddr;
                write_q  <= hwrite;
                wait_cnt <= 4'(WAIT_STATES - 1);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // NOTE: the memory array has no reset; contents survive hrstn by design.
    always_ff @(posedge hclk) begin
        if (state == S_DATA && write_q) mem[mem_idx] <= hwdata;
    end

    assign gen_burst = is_nonseq ? hburst : burst_q;
    assign gen_beat  = is_nonseq ? 3'd0 : beat_q;

    ahb_burst_addr_gen u_addr_gen (
        .burst         (gen_burst),
        .addr          (haddr),
        .beat_cnt      (gen_beat),
        .next_addr     (gen_next_addr),
        .next_beat_cnt (gen_next_beat),
        .last_beat     (gen_last)
    );

    // A stray SEQ with no open burst is flagged but does not open one.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            burst_open <= 1'b0;
            exp_addr   <= '0;
            burst_q    <= BURST_SINGLE;
            beat_q     <= '0;
            seq_viol   <= 1'b0;
        end else begin
            seq_viol <= accept && is_seq && (!burst_open || haddr != exp_addr);
            if (accept && is_nonseq) burst_q <= hburst;
            if (accept && (is_nonseq || burst_open)) begin
                exp_addr   <= gen_next_addr;
                beat_q     <= gen_next_beat;
                burst_open <= !gen_last;
            end
        end
    end

endmodule
